i281_fetch_decode: RTL

//  Instruction fetch/decode stage feeding the i281 control logic. Owns the PC, fetches 16-bit

---
 rtl/i281_pkg.sv | 66 ++++++
 rtl/i281_instr_decode.sv | 48 ++++
 rtl/i281_fetch_decode.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/i281_pkg.sv
// Shared definitions for the i281 fetch/decode stage: opcodes, one-hot op
// indices, sub-function lookup tables and the stage FSM state type.
package i281_pkg;

  localparam int OP_W    = 27;
  localparam int INSTR_W = 16;
  localparam int OPS_N   = 23;

  // Major opcodes, instruction bits [15:12]
  localparam logic [3:0] OPC_NOOP   = 4'h0;
  localparam logic [3:0] OPC_INPUT  = 4'h1;
  localparam logic [3:0] OPC_MOVE   = 4'h2;
  localparam logic [3:0] OPC_LOADI  = 4'h3;
  localparam logic [3:0] OPC_ADD    = 4'h4;
  localparam logic [3:0] OPC_ADDI   = 4'h5;
  localparam logic [3:0] OPC_SUB    = 4'h6;
  localparam logic [3:0] OPC_SUBI   = 4'h7;
  localparam logic [3:0] OPC_LOAD   = 4'h8;
  localparam logic [3:0] OPC_LOADF  = 4'h9;
  localparam logic [3:0] OPC_STORE  = 4'hA;
  localparam logic [3:0] OPC_STOREF = 4'hB;
  localparam logic [3:0] OPC_SHIFT  = 4'hC;
  localparam logic [3:0] OPC_CMP    = 4'hD;
  localparam logic [3:0] OPC_JUMP   = 4'hE;
  localparam logic [3:0] OPC_BRANCH = 4'hF;

  // Bit positions inside op_out[22:0]
  localparam logic [4:0] OP_NOOP    = 5'd0;
  localparam logic [4:0] OP_INPUTC  = 5'd1;
  localparam logic [4:0] OP_INPUTCF = 5'd2;
  localparam logic [4:0] OP_INPUTD  = 5'd3;
  localparam logic [4:0] OP_INPUTDF = 5'd4;
  localparam logic [4:0] OP_MOVE    = 5'd5;
  localparam logic [4:0] OP_LOADI   = 5'd6;
  localparam logic [4:0] OP_ADD     = 5'd7;
  localparam logic [4:0] OP_ADDI    = 5'd8;
  localparam logic [4:0] OP_SUB     = 5'd9;
  localparam logic [4:0] OP_SUBI    = 5'd10;
  localparam logic [4:0] OP_LOAD    = 5'd11;
  localparam logic [4:0] OP_LOADF   = 5'd12;
  localparam logic [4:0] OP_STORE   = 5'd13;
  localparam logic [4:0] OP_STOREF  = 5'd14;
  localparam logic [4:0] OP_SHIFTL  = 5'd15;
  localparam logic [4:0] OP_SHIFTR  = 5'd16;
  localparam logic [4:0] OP_CMP     = 5'd17;
  localparam logic [4:0] OP_JUMP    = 5'd18;
  localparam logic [4:0] OP_BRE     = 5'd19;
  localparam logic [4:0] OP_BRNE    = 5'd20;
  localparam logic [4:0] OP_BRG     = 5'd21;
  localparam logic [4:0] OP_BRGE    = 5'd22;

  // Sub-function selects: INPUT and BRANCH use bits [9:8], SHIFT uses bit [8].
  // A SHIFT with bit [9] set is a reserved (illegal) encoding.
  localparam logic [4:0] INPUT_OP  [4] = '{OP_INPUTC, OP_INPUTCF, OP_INPUTD, OP_INPUTDF};
  localparam logic [4:0] SHIFT_OP  [2] = '{OP_SHIFTL, OP_SHIFTR};
  localparam logic [4:0] BRANCH_OP [4] = '{OP_BRE, OP_BRNE, OP_BRG, OP_BRGE};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

endpackage

// File: rtl/i281_instr_decode.sv
// Combinational i281 instruction decoder: 16-bit instruction to the 27-bit
// {RX, RY, one-hot op} word plus an illegal-encoding flag.
module i281_instr_decode
  import i281_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic [OP_W-1:0]    op_word,
  output logic               illegal
);

  logic [4:0]       op_idx;
  logic [OPS_N-1:0] op_onehot;
  logic             unused_imm_bits;

  // The imm/offset byte is carried by the fetch stage, not decoded here
  assign unused_imm_bits = ^instr[7:0];

  // Map opcode and sub-function select to a single op index
  always_comb begin
    illegal = 1'b0;
    op_idx  = OP_NOOP;
    case (instr[15:12])
      OPC_NOOP:   op_idx = OP_NOOP;
      OPC_INPUT:  op_idx = INPUT_OP[instr[9:8]];
      OPC_MOVE:   op_idx = OP_MOVE;
      OPC_LOADI:  op_idx = OP_LOADI;
      OPC_ADD:    op_idx = OP_ADD;
      OPC_ADDI:   op_idx = OP_ADDI;
      OPC_SUB:    op_idx = OP_SUB;
      OPC_SUBI:   op_idx = OP_SUBI;
      OPC_LOAD:   op_idx = OP_LOAD;
      OPC_LOADF:  op_idx = OP_LOADF;
      OPC_STORE:  op_idx = OP_STORE;
      OPC_STOREF: op_idx = OP_STOREF;
      OPC_SHIFT: begin
        op_idx  = SHIFT_OP[instr[8]];
        illegal = instr[9];
      end
      OPC_CMP:    op_idx = OP_CMP;
      OPC_JUMP:   op_idx = OP_JUMP;
      OPC_BRANCH: op_idx = BRANCH_OP[instr[9:8]];
      default:    op_idx = OP_NOOP;
    endcase
    op_onehot = OPS_N'(1) << op_idx;
    op_word   = {instr[11:10], instr[9:8], op_onehot};
  end

endmodule

// File: rtl/i281_fetch_decode.sv
// i281 fetch/decode stage: owns the PC, fetches over a req/ack handshake,
// decodes, presents the op word for one execute cycle and then advances the
// PC using the taken-branch bit from the control logic.
module i281_fetch_decode
  import i281_pkg::*;
#(
  parameter int PC_W      = 6,
  parameter int RUN_LIMIT = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               run,
  input  logic               step,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [OP_W-1:0]    op_out,
  output logic [7:0]         imm_out,
  output logic               op_valid,
  input  logic               branch_taken,
  output logic [PC_W-1:0]    pc,
  output logic               halted
);

  state_t               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [OP_W-1:0]      op_q, op_d;
  logic [7:0]           imm_q, imm_d;
  logic                 valid_q, valid_d;
  logic                 req_q, req_d;
  logic                 halted_q, halted_d;
  logic                 step_pend_q, step_pend_d;
  logic [31:0]          count_q, count_d;
  logic [OP_W-1:0]      dec_op;
  logic                 dec_illegal;
  logic [PC_W-1:0]      br_off;

  i281_instr_decode u_decode (
    .instr   (instr_q),
    .op_word (dec_op),
    .illegal (dec_illegal)
  );

  // Branch offset is a signed byte, reduced modulo 2^PC_W
  assign br_off = PC_W'($signed(imm_q));

  // Next-state, PC and output register computation
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    op_d        = op_q;
    imm_d       = imm_q;
    valid_d     = valid_q;
    req_d       = req_q;
    halted_d    = halted_q;
    count_d     = count_q;
    // A step seen while not free-running is remembered until IDLE consumes it
    step_pend_d = step_pend_q | (step & ~run);
    case (state_q)
      ST_IDLE: begin
        if (run || step || step_pend_q) begin
          state_d     = ST_FETCH;
          req_d       = 1'b1;
          step_pend_d = 1'b0;
        end
      end
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          req_d   = 1'b0;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        imm_d = instr_q[7:0];
        if (dec_illegal) begin
          op_d     = '0;
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else begin
          op_d    = dec_op;
          valid_d = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        valid_d = 1'b0;
        op_d    = '0;
        pc_d    = branch_taken ? (pc_q + PC_W'(1) + br_off) : (pc_q + PC_W'(1));
        count_d = count_q + 32'd1;
        if ((RUN_LIMIT != 0) && (count_d == 32'(RUN_LIMIT))) begin
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else if (run) begin
          req_d   = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT: begin
        step_pend_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset drops imem_req immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      instr_q     <= '0;
      op_q        <= '0;
      imm_q       <= '0;
      valid_q     <= 1'b0;
      req_q       <= 1'b0;
      halted_q    <= 1'b0;
      step_pend_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      op_q        <= op_d;
      imm_q       <= imm_d;
      valid_q     <= valid_d;
      req_q       <= req_d;
      halted_q    <= halted_d;
      step_pend_q <= step_pend_d;
      count_q     <= count_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign op_out    = op_q;
  assign imm_out   = imm_q;
  assign op_valid  = valid_q;
  assign pc        = pc_q;
  assign halted    = halted_q;

endmodule
